// File: rtl/store_buf_pkg.sv
// Shared constants, entry layout and address-match helper for the store buffer.
// Optional load forwarding is selected with the STORE_BUF_FWD_EN macro.
package store_buf_pkg;

    localparam int SB_DEPTH = 4;
    localparam int SB_PTR_W = 2;
    localparam int SB_BE_W  = 4;

    // Only the word address is kept; mem_addr[1:0] is always presented as zero.
    typedef struct packed {
        logic [29:0]         word;
        logic [SB_BE_W-1:0]  byteen;
        logic [31:0]         wdata;
    } sb_entry_t;

    function automatic logic word_match(
        input logic        entry_valid,
        input logic [29:0] entry_word,
        input logic [31:0] addr
    );
        return entry_valid && (entry_word == addr[31:2]);
    endfunction

endpackage

// File: rtl/store_buf_if.sv
// Store-side, DM-side and load-lookup signals of the store buffer.
// master = pipeline/memory side, slave = store buffer.
interface store_buf_if;
    import store_buf_pkg::*;

    logic                st_valid;
    logic [31:0]         st_addr;
    logic [SB_BE_W-1:0]  st_byteen;
    logic [31:0]         st_wdata;
    logic                st_stall;
    logic                mem_we;
    logic [31:0]         mem_addr;
    logic [SB_BE_W-1:0]  mem_byteen;
    logic [31:0]         mem_wdata;
    logic                mem_ready;
    logic                ld_valid;
    logic [31:0]         ld_addr;
    logic                ld_conflict;
    logic [SB_BE_W-1:0]  fwd_mask;
    logic [31:0]         fwd_data;
    logic                empty;

    modport master (
        output st_valid, st_addr, st_byteen, st_wdata, mem_ready, ld_valid, ld_addr,
        input  st_stall, mem_we, mem_addr, mem_byteen, mem_wdata, ld_conflict,
               fwd_mask, fwd_data, empty
    );

    modport slave (
        input  st_valid, st_addr, st_byteen, st_wdata, mem_ready, ld_valid, ld_addr,
        output st_stall, mem_we, mem_addr, mem_byteen, mem_wdata, ld_conflict,
               fwd_mask, fwd_data, empty
    );

endinterface

// File: rtl/store_buf_fwd.sv
// Combinational youngest-first lane merge of buffered stores onto a load word.
// Only present when STORE_BUF_FWD_EN is defined.
`ifdef STORE_BUF_FWD_EN
module store_buf_fwd
    import store_buf_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int PTR_W = SB_PTR_W
) (
    input  sb_entry_t [DEPTH-1:0] entry,
    input  logic [DEPTH-1:0]      valid,
    input  logic [PTR_W-1:0]      head,
    input  logic [31:0]           ld_addr,
    output logic [SB_BE_W-1:0]    fwd_mask,
    output logic [31:0]           fwd_data
);

    logic [PTR_W-1:0] idx_s;
    logic             hit_s;
    logic             unused_s;

    assign unused_s = ^ld_addr[1:0];

    // Walk oldest to youngest so a younger store overwrites an older one lane by lane.
    always_comb begin
        fwd_mask = {SB_BE_W{1'b0}};
        fwd_data = 32'h0000_0000;
        idx_s    = head;
        hit_s    = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            idx_s = head + PTR_W'(i);
            for (int l = 0; l < SB_BE_W; l++) begin
                hit_s = word_match(valid[idx_s], entry[idx_s].word, ld_addr) &&
                        entry[idx_s].byteen[l];
                fwd_mask[l]      = fwd_mask[l] | hit_s;
                fwd_data[8*l +: 8] = hit_s ? entry[idx_s].wdata[8*l +: 8] : fwd_data[8*l +: 8];
            end
        end
    end

endmodule
`endif

// File: rtl/store_buf.sv
// In-order store buffer between the byte-enable unit and the data-memory write port.
// Define STORE_BUF_FWD_EN to forward buffered bytes to loads instead of stalling them.
module store_buf
    import store_buf_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int PTR_W = SB_PTR_W
) (
    input logic        clk,
    input logic        reset,
    store_buf_if.slave sb
);

    sb_entry_t [DEPTH-1:0] entry_r;
    logic [DEPTH-1:0]      valid_r;
    logic [PTR_W-1:0]      head_r;
    logic [PTR_W-1:0]      tail_r;
    logic [PTR_W:0]        count_r;
    logic                  mem_we_r;
    logic                  empty_r;
    sb_entry_t             mem_r;

    logic                  full_s;
    logic                  push_s;
    logic                  pop_s;
    logic [PTR_W-1:0]      head_nxt_s;
    logic [PTR_W-1:0]      tail_nxt_s;
    logic [PTR_W:0]        count_nxt_s;
    logic [DEPTH-1:0]      valid_nxt_s;
    sb_entry_t             new_s;
    sb_entry_t             mem_nxt_s;
    logic                  ld_conflict_s;
    logic [SB_BE_W-1:0]    fwd_mask_s;
    logic [31:0]           fwd_data_s;
    logic                  unused_s;

    assign full_s = (count_r == (PTR_W+1)'(DEPTH));
    assign push_s = sb.st_valid && !full_s && (sb.st_byteen != 4'b0000);
    assign pop_s  = mem_we_r && sb.mem_ready;
    assign new_s  = {sb.st_addr[31:2], sb.st_byteen, sb.st_wdata};

    // Pointer, occupancy and valid-bit updates, plus the entry that will sit at the head next cycle.
    always_comb begin
        head_nxt_s  = head_r;
        tail_nxt_s  = tail_r;
        count_nxt_s = count_r;
        valid_nxt_s = valid_r;
        mem_nxt_s   = entry_r[head_r];
        if (pop_s) begin
            head_nxt_s          = head_r + PTR_W'(1);
            valid_nxt_s[head_r] = 1'b0;
        end else begin
            head_nxt_s = head_r;
        end
        if (push_s) begin
            tail_nxt_s          = tail_r + PTR_W'(1);
            valid_nxt_s[tail_r] = 1'b1;
        end else begin
            tail_nxt_s = tail_r;
        end
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + (PTR_W+1)'(1);
            2'b01:   count_nxt_s = count_r - (PTR_W+1)'(1);
            default: count_nxt_s = count_r;
        endcase
        // A store landing in the slot that becomes head must bypass the array to meet N+1 latency.
        if (push_s && (tail_r == head_nxt_s)) begin
            mem_nxt_s = new_s;
        end else begin
            mem_nxt_s = entry_r[head_nxt_s];
        end
    end

    // Entry array, pointers and the registered DM-side outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            entry_r  <= {DEPTH{{$bits(sb_entry_t){1'b0}}}};
            valid_r  <= {DEPTH{1'b0}};
            head_r   <= {PTR_W{1'b0}};
            tail_r   <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W+1){1'b0}};
            mem_r    <= {$bits(sb_entry_t){1'b0}};
            mem_we_r <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (push_s) begin
                entry_r[tail_r] <= new_s;
            end
            valid_r  <= valid_nxt_s;
            head_r   <= head_nxt_s;
            tail_r   <= tail_nxt_s;
            count_r  <= count_nxt_s;
            mem_r    <= mem_nxt_s;
            mem_we_r <= (count_nxt_s != {(PTR_W+1){1'b0}});
            empty_r  <= (count_nxt_s == {(PTR_W+1){1'b0}});
        end
    end

`ifdef STORE_BUF_FWD_EN
    store_buf_fwd #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fwd (
        .entry    (entry_r),
        .valid    (valid_r),
        .head     (head_r),
        .ld_addr  (sb.ld_addr),
        .fwd_mask (fwd_mask_s),
        .fwd_data (fwd_data_s)
    );

    assign ld_conflict_s = 1'b0;
    assign unused_s      = ^{sb.st_addr[1:0], sb.ld_valid};
`else
    // Without forwarding, any buffered store to the load's word holds the load off.
    always_comb begin
        ld_conflict_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            ld_conflict_s = ld_conflict_s | word_match(valid_r[i], entry_r[i].word, sb.ld_addr);
        end
        ld_conflict_s = ld_conflict_s & sb.ld_valid;
    end

    assign fwd_mask_s = {SB_BE_W{1'b0}};
    assign fwd_data_s = 32'h0000_0000;
    assign unused_s   = ^{sb.st_addr[1:0], sb.ld_addr[1:0]};
`endif

    assign sb.st_stall    = sb.st_valid && full_s;
    assign sb.mem_we      = mem_we_r;
    assign sb.mem_addr    = {mem_r.word, 2'b00};
    assign sb.mem_byteen  = mem_r.byteen;
    assign sb.mem_wdata   = mem_r.wdata;
    assign sb.empty       = empty_r;
    assign sb.ld_conflict = ld_conflict_s;
    assign sb.fwd_mask    = fwd_mask_s;
    assign sb.fwd_data    = fwd_data_s;

endmodule

// File: tb/tb_store_buf.sv
// Self-checking bench for store_buf: directed vector table, corner sequences and a random
// phase compared against a queue-based reference model.
module tb_store_buf;

    localparam int DEPTH = 4;
`ifdef STORE_BUF_FWD_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    typedef struct {
        logic        rst;
        logic        sv;
        logic [31:0] sa;
        logic [3:0]  sb;
        logic [31:0] sd;
        logic        mr;
        logic        lv;
        logic [31:0] la;
        logic        e_stall;
        logic        e_we;
        logic [31:0] e_addr;
        logic        e_empty;
        logic        e_conf;
        logic [3:0]  e_mask;
        logic [31:0] e_fdata;
    } vec_t;

    typedef struct {
        logic [31:0] a;
        logic [3:0]  b;
        logic [31:0] d;
    } ent_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    ent_t q[$];
    vec_t tbl[$];

    store_buf_if sbif ();

    store_buf dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sbif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(
        input logic rst, input logic sv, input logic [31:0] sa, input logic [3:0] sb,
        input logic [31:0] sd, input logic mr, input logic lv, input logic [31:0] la,
        input logic e_stall, input logic e_we, input logic [31:0] e_addr, input logic e_empty,
        input logic e_conf, input logic [3:0] e_mask, input logic [31:0] e_fdata
    );
        vec_t v;
        v.rst = rst; v.sv = sv; v.sa = sa; v.sb = sb; v.sd = sd; v.mr = mr; v.lv = lv; v.la = la;
        v.e_stall = e_stall; v.e_we = e_we; v.e_addr = e_addr; v.e_empty = e_empty;
        v.e_conf = e_conf; v.e_mask = e_mask; v.e_fdata = e_fdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: pending stores as a FIFO; lookups scan oldest to youngest.
    task automatic model_check(input vec_t v);
        logic        any;
        logic [3:0]  mask;
        logic [31:0] data;
        any = 1'b0; mask = 4'h0; data = 32'h0;
        foreach (q[i]) begin
            if (q[i].a[31:2] == v.la[31:2]) begin
                any = 1'b1;
                for (int l = 0; l < 4; l++) begin
                    if (q[i].b[l]) begin
                        mask[l] = 1'b1;
                        data[8*l +: 8] = q[i].d[8*l +: 8];
                    end
                end
            end
        end
        chk("m_stall", sbif.st_stall, v.sv && (q.size() == DEPTH));
        chk("m_we", sbif.mem_we, q.size() != 0);
        chk("m_empty", sbif.empty, q.size() == 0);
        if (q.size() != 0) begin
            chk("m_addr", sbif.mem_addr, {q[0].a[31:2], 2'b00});
            chk("m_byteen", sbif.mem_byteen, q[0].b);
            chk("m_wdata", sbif.mem_wdata, q[0].d);
        end
        chk("m_conf", sbif.ld_conflict, FWD_ON ? 1'b0 : (v.lv && any));
        chk("m_mask", sbif.fwd_mask, FWD_ON ? mask : 4'h0);
        chk("m_fdata", sbif.fwd_data, FWD_ON ? data : 32'h0);
    endtask

    task automatic model_step(input vec_t v);
        logic full;
        logic do_pop;
        ent_t e;
        if (v.rst) begin
            q.delete();
        end else begin
            full   = (q.size() == DEPTH);
            do_pop = (q.size() != 0) && v.mr;
            if (do_pop) void'(q.pop_front());
            if (v.sv && !full && (v.sb != 4'h0)) begin
                e.a = v.sa; e.b = v.sb; e.d = v.sd;
                q.push_back(e);
            end
        end
    endtask

    task automatic run_cycle(input vec_t v, input bit expl, input string tag);
        reset          = v.rst;
        sbif.st_valid  = v.sv;
        sbif.st_addr   = v.sa;
        sbif.st_byteen = v.sb;
        sbif.st_wdata  = v.sd;
        sbif.mem_ready = v.mr;
        sbif.ld_valid  = v.lv;
        sbif.ld_addr   = v.la;
        #2;
        model_check(v);
        if (expl) begin
            chk({tag, "_stall"}, sbif.st_stall, v.e_stall);
            chk({tag, "_we"}, sbif.mem_we, v.e_we);
            if (v.e_we) chk({tag, "_addr"}, sbif.mem_addr, v.e_addr);
            chk({tag, "_empty"}, sbif.empty, v.e_empty);
            chk({tag, "_conf"}, sbif.ld_conflict, FWD_ON ? 1'b0 : v.e_conf);
            chk({tag, "_mask"}, sbif.fwd_mask, FWD_ON ? v.e_mask : 4'h0);
            chk({tag, "_fdata"}, sbif.fwd_data, FWD_ON ? v.e_fdata : 32'h0);
        end
        @(posedge clk);
        model_step(v);
        #1;
    endtask

    initial begin
        vec_t v;
        checks = 0;
        errors = 0;
        reset = 1'b1;
        sbif.st_valid = 1'b0; sbif.st_addr = 32'h0; sbif.st_byteen = 4'h0; sbif.st_wdata = 32'h0;
        sbif.mem_ready = 1'b0; sbif.ld_valid = 1'b0; sbif.ld_addr = 32'h0;
        @(posedge clk);
        #1;
        q.delete();

        // rst sv addr be data mr lv la | stall we addr empty conf mask fdata
        tbl.push_back(mk(1, 0, 32'h0,    4'h0, 32'h0,        0, 0, 32'h0,   0, 0, 32'h0,    1, 0, 4'h0, 32'h0));
        tbl.push_back(mk(0, 1, 32'h1004, 4'hF, 32'hDEADBEEF, 1, 0, 32'h0,   0, 0, 32'h0,    1, 0, 4'h0, 32'h0));
        tbl.push_back(mk(0, 0, 32'h0,    4'h0, 32'h0,        1, 0, 32'h0,   0, 1, 32'h1004, 0, 0, 4'h0, 32'h0));
        tbl.push_back(mk(0, 0, 32'h0,    4'h0, 32'h0,        1, 0, 32'h0,   0, 0, 32'h0,    1, 0, 4'h0, 32'h0));
        tbl.push_back(mk(0, 1, 32'h3000, 4'h0, 32'h12345678, 1, 0, 32'h0,   0, 0, 32'h0,    1, 0, 4'h0, 32'h0));
        tbl.push_back(mk(0, 0, 32'h0,    4'h0, 32'h0,        1, 0, 32'h0,   0, 0, 32'h0,    1, 0, 4'h0, 32'h0));
        tbl.push_back(mk(0, 1, 32'h100,  4'hF, 32'h11111111, 0, 0, 32'h0,   0, 0, 32'h0,    1, 0, 4'h0, 32'h0));
        tbl.push_back(mk(0, 1, 32'h104,  4'hF, 32'h22222222, 0, 0, 32'h0,   0, 1, 32'h100,  0, 0, 4'h0, 32'h0));
        tbl.push_back(mk(0, 1, 32'h108,  4'hF, 32'h33333333, 0, 1, 32'h200, 0, 1, 32'h100,  0, 0, 4'h0, 32'h0));
        tbl.push_back(mk(0, 1, 32'h10C,  4'hF, 32'h44444444, 0, 1, 32'h106, 0, 1, 32'h100,  0, 1, 4'hF, 32'h22222222));
        tbl.push_back(mk(0, 1, 32'h110,  4'hF, 32'h55555555, 0, 0, 32'h0,   1, 1, 32'h100,  0, 0, 4'h0, 32'h0));
        tbl.push_back(mk(0, 1, 32'h110,  4'hF, 32'h55555555, 1, 0, 32'h0,   1, 1, 32'h100,  0, 0, 4'h0, 32'h0));
        tbl.push_back(mk(0, 1, 32'h110,  4'hF, 32'h55555555, 1, 0, 32'h0,   0, 1, 32'h104,  0, 0, 4'h0, 32'h0));
        tbl.push_back(mk(0, 0, 32'h0,    4'h0, 32'h0,        1, 1, 32'h110, 0, 1, 32'h108,  0, 1, 4'hF, 32'h55555555));
        tbl.push_back(mk(0, 0, 32'h0,    4'h0, 32'h0,        1, 0, 32'h0,   0, 1, 32'h10C,  0, 0, 4'h0, 32'h0));
        tbl.push_back(mk(0, 0, 32'h0,    4'h0, 32'h0,        1, 0, 32'h0,   0, 1, 32'h110,  0, 0, 4'h0, 32'h0));
        tbl.push_back(mk(0, 0, 32'h0,    4'h0, 32'h0,        1, 0, 32'h0,   0, 0, 32'h0,    1, 0, 4'h0, 32'h0));
        foreach (tbl[i]) run_cycle(tbl[i], 1'b1, $sformatf("tbl%0d", i));

        // Two byte stores to the same lane: the younger one must win, or the load waits for both.
        run_cycle(mk(0, 1, 32'h2001, 4'h2, 32'h0000AB00, 0, 0, 32'h0,    0, 0, 32'h0,    1, 0, 4'h0, 32'h0), 1'b1, "fwd0");
        run_cycle(mk(0, 1, 32'h2001, 4'h2, 32'h0000CD00, 0, 0, 32'h0,    0, 1, 32'h2000, 0, 0, 4'h0, 32'h0), 1'b1, "fwd1");
        run_cycle(mk(0, 0, 32'h0,    4'h0, 32'h0,        0, 1, 32'h2000, 0, 1, 32'h2000, 0, 1, 4'h2, 32'h0000CD00), 1'b1, "fwd2");
        run_cycle(mk(0, 0, 32'h0,    4'h0, 32'h0,        1, 1, 32'h2000, 0, 1, 32'h2000, 0, 1, 4'h2, 32'h0000CD00), 1'b1, "fwd3");
        run_cycle(mk(0, 0, 32'h0,    4'h0, 32'h0,        1, 1, 32'h2000, 0, 1, 32'h2000, 0, 1, 4'h2, 32'h0000CD00), 1'b1, "fwd4");
        run_cycle(mk(0, 0, 32'h0,    4'h0, 32'h0,        1, 1, 32'h2000, 0, 0, 32'h0,    1, 0, 4'h0, 32'h0), 1'b1, "fwd5");

        // Occupancy held at two by push+pop every cycle; pointers wrap twice over eight stores.
        run_cycle(mk(0, 1, 32'h3000, 4'hF, 32'hA0000000, 0, 0, 32'h0, 0, 0, 32'h0,    1, 0, 4'h0, 32'h0), 1'b1, "wrp_a");
        run_cycle(mk(0, 1, 32'h3004, 4'hF, 32'hA0000001, 0, 0, 32'h0, 0, 1, 32'h3000, 0, 0, 4'h0, 32'h0), 1'b1, "wrp_b");
        for (int k = 0; k < 6; k++) begin
            run_cycle(mk(0, 1, 32'h3008 + 32'(4*k), 4'hF, 32'hA0000002 + 32'(k), 1, 0, 32'h0,
                         0, 1, 32'h3000 + 32'(4*k), 0, 0, 4'h0, 32'h0), 1'b1, $sformatf("wrp%0d", k));
        end
        run_cycle(mk(0, 0, 32'h0, 4'h0, 32'h0, 1, 0, 32'h0, 0, 1, 32'h3018, 0, 0, 4'h0, 32'h0), 1'b1, "wrp_d0");
        run_cycle(mk(0, 0, 32'h0, 4'h0, 32'h0, 1, 0, 32'h0, 0, 1, 32'h301C, 0, 0, 4'h0, 32'h0), 1'b1, "wrp_d1");
        run_cycle(mk(0, 0, 32'h0, 4'h0, 32'h0, 1, 0, 32'h0, 0, 0, 32'h0,    1, 0, 4'h0, 32'h0), 1'b1, "wrp_d2");

        // Reset with three stores pending and DM not ready: nothing may survive.
        run_cycle(mk(0, 1, 32'h5000, 4'hF, 32'hB0, 0, 0, 32'h0, 0, 0, 32'h0,    1, 0, 4'h0, 32'h0), 1'b1, "rst_a");
        run_cycle(mk(0, 1, 32'h5004, 4'hF, 32'hB1, 0, 0, 32'h0, 0, 1, 32'h5000, 0, 0, 4'h0, 32'h0), 1'b1, "rst_b");
        run_cycle(mk(0, 1, 32'h5008, 4'hF, 32'hB2, 0, 0, 32'h0, 0, 1, 32'h5000, 0, 0, 4'h0, 32'h0), 1'b1, "rst_c");
        run_cycle(mk(1, 0, 32'h0,    4'h0, 32'h0,  0, 0, 32'h0, 0, 1, 32'h5000, 0, 0, 4'h0, 32'h0), 1'b1, "rst_d");
        run_cycle(mk(0, 0, 32'h0,    4'h0, 32'h0,  1, 1, 32'h5004, 0, 0, 32'h0, 1, 0, 4'h0, 32'h0), 1'b1, "rst_e");
        run_cycle(mk(0, 0, 32'h0,    4'h0, 32'h0,  1, 0, 32'h0, 0, 0, 32'h0,    1, 0, 4'h0, 32'h0), 1'b1, "rst_f");

        // Random traffic over a small address pool so word matches and full conditions are frequent.
        for (int n = 0; n < 400; n++) begin
            v = mk(0, 0, 32'h0, 4'h0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 4'h0, 32'h0);
            v.rst = ($urandom_range(0, 59) == 0);
            v.sv  = ($urandom_range(0, 9) < 6);
            v.sa  = 32'h4000 + 32'($urandom_range(0, 3)) * 32'd4 + 32'($urandom_range(0, 3));
            v.sb  = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            v.sd  = $urandom;
            v.mr  = ($urandom_range(0, 9) < 4);
            v.lv  = ($urandom_range(0, 1) == 1);
            v.la  = 32'h4000 + 32'($urandom_range(0, 4)) * 32'd4 + 32'($urandom_range(0, 3));
            run_cycle(v, 1'b0, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
